// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller. Generates PC hold and pipeline
// register stall/flush controls for load-use hazards, taken branches and
// data-memory wait states, with a sticky memory-timeout error and a
// saturating count of PC-hold cycles.
module hazard_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             hazardpc_o,
    output logic             hold_ifid_o,
    output logic             flush_ifid_o,
    output logic             hold_idex_o,
    output logic             flush_idex_o,
    output logic             hold_exmem_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned       WC_W       = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0]   WAIT_LIMIT = WC_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WC_W-1:0]   wait_inc;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_stall;
    logic              rs1_hit, rs2_hit, lu;

    // A pending memory access that is not completing this cycle freezes everything.
    assign mem_stall = mem_req_i & ~mem_ready_i;

    // Load-use: the load in EX writes a register the ID instruction reads; x0 never matches.
    assign rs1_hit = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    assign lu      = ex_memread_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

    assign wait_inc = wait_cnt_q + WC_W'(1);

    // State and consecutive-wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state: count consecutive memory-stall cycles, trap into ERROR at the limit.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output decode in priority order: error, memory freeze, branch flush, load-use bubble.
    always_comb begin
        hazardpc_o    = 1'b0;
        hold_ifid_o   = 1'b0;
        flush_ifid_o  = 1'b0;
        hold_idex_o   = 1'b0;
        flush_idex_o  = 1'b0;
        hold_exmem_o  = 1'b0;
        mem_timeout_o = 1'b0;
        if (state_q == ST_ERROR) begin
            hazardpc_o    = 1'b1;
            hold_ifid_o   = 1'b1;
            hold_idex_o   = 1'b1;
            hold_exmem_o  = 1'b1;
            mem_timeout_o = 1'b1;
        end else if (mem_stall) begin
            // No flush here: a taken branch waits in EX until the freeze ends.
            hazardpc_o   = 1'b1;
            hold_ifid_o  = 1'b1;
            hold_idex_o  = 1'b1;
            hold_exmem_o = 1'b1;
        end else if (branch_taken_i) begin
            // The ID instruction is on the wrong path, so its load-use match is irrelevant.
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
        end else if (lu) begin
            hazardpc_o   = 1'b1;
            hold_ifid_o  = 1'b1;
            flush_idex_o = 1'b1;
        end
    end

    // Saturating increment of the PC-hold cycle count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazardpc_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // PC-hold performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit with TIMEOUT=4, CNT_W=4.
module tb_hazard_unit;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 4;

    logic                clk;
    logic                rst_n;
    logic [4:0]          id_rs1, id_rs2, ex_rd;
    logic                id_use_rs1, id_use_rs2, ex_memread;
    logic                branch_taken, mem_req, mem_ready;
    logic                hazardpc, hold_ifid, flush_ifid, hold_idex, flush_idex, hold_exmem;
    logic                mem_timeout;
    logic [TB_CNT_W-1:0] stall_cnt;

    int n_checks;
    int n_errors;

    // expected: {ctrl[6:0], cnt[3:0]}; ctrl = {hpc, hold_ifid, flush_ifid, hold_idex, flush_idex, hold_exmem, timeout}
    logic [10:0] sb[$];

    // reference model state
    logic        m_err;
    int          m_run;
    int          m_cnt;

    hazard_unit #(
        .TIMEOUT(TB_TIMEOUT),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .ex_rd_i       (ex_rd),
        .ex_memread_i  (ex_memread),
        .branch_taken_i(branch_taken),
        .mem_req_i     (mem_req),
        .mem_ready_i   (mem_ready),
        .hazardpc_o    (hazardpc),
        .hold_ifid_o   (hold_ifid),
        .flush_ifid_o  (flush_ifid),
        .hold_idex_o   (hold_idex),
        .flush_idex_o  (flush_idex),
        .hold_exmem_o  (hold_exmem),
        .mem_timeout_o (mem_timeout),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_err = 1'b0;
        m_run = 0;
        m_cnt = 0;
    endtask

    // Drive one cycle of inputs (at posedge+1), push the expectation, compare mid-cycle,
    // then advance the model across the next rising edge.
    task automatic step(input string tag,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr,
                        input logic br, input logic req, input logic rdy);
        logic        ms, luh;
        logic [6:0]  ec;
        logic [10:0] e;
        logic [6:0]  oc;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_memread = mr; branch_taken = br; mem_req = req; mem_ready = rdy;
        ms  = req & ~rdy;
        luh = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (m_err)     ec = 7'b1101011;
        else if (ms)   ec = 7'b1101010;
        else if (br)   ec = 7'b0010100;
        else if (luh)  ec = 7'b1100100;
        else           ec = 7'b0000000;
        sb.push_back({ec, 4'(m_cnt)});
        #5;
        oc = {hazardpc, hold_ifid, flush_ifid, hold_idex, flush_idex, hold_exmem, mem_timeout};
        check({tag, "_sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_ctrl"}, 32'(oc), 32'(e[10:4]));
            check({tag, "_cnt"}, 32'(stall_cnt), 32'(e[3:0]));
            if (rst_n) begin
                if (e[10] && m_cnt != 15) m_cnt++;
                if (!m_err) begin
                    if (ms) begin
                        m_run++;
                        if (m_run == int'(TB_TIMEOUT)) m_err = 1'b1;
                    end else begin
                        m_run = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lu_rs2(input string tag);
        step(tag, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stall(input string tag, input logic br);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, 1'b1, 1'b0);
    endtask

    task automatic sync_reset_pulse();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_memread = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        // reset state, and combinational terms still live during reset
        idle("rst_idle");
        lu_rs2("rst_lu");
        idle("rst_idle2");
        rst_n = 1'b1;

        // load-use on rs2: one bubble, counter 0 -> 1
        lu_rs2("lu_rs2");
        idle("lu_after");
        // load-use on rs1
        step("lu_rs1", 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        // x0 never a hazard
        step("lu_x0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // rs2 match but not used
        step("lu_nouse", 5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        // match but EX not a load
        step("lu_noload", 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        // branch overrides load-use
        step("br_lu", 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("br_after");

        // memory wait with pending branch, counter starts fresh
        sync_reset_pulse();
        stall("mw1", 1'b1);
        stall("mw2", 1'b1);
        stall("mw3", 1'b1);
        step("mw_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle("mw_end");

        // three stalls then ready: no timeout
        stall("nt1", 1'b0);
        stall("nt2", 1'b0);
        stall("nt3", 1'b0);
        step("nt_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("nt_idle");
        // one-cycle break resets the count
        stall("br1", 1'b0);
        stall("br2", 1'b0);
        stall("br3", 1'b0);
        idle("brk");
        stall("br4", 1'b0);
        stall("br5", 1'b0);
        stall("br6", 1'b0);
        idle("brk_end");

        // four stalls: ERROR from the fifth cycle, sticky after ready
        stall("to1", 1'b0);
        stall("to2", 1'b0);
        stall("to3", 1'b0);
        stall("to4", 1'b0);
        step("to5_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("to6");
        step("to7_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // asynchronous reset mid-cycle while in ERROR
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_timeout", 32'(mem_timeout), 32'd0);
        check("arst_cnt", 32'(stall_cnt), 32'd0);
        check("arst_hpc", 32'(hazardpc), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("arst_after");

        // counter saturation with 20 load-use cycles
        for (int i = 0; i < 20; i++) begin
            lu_rs2($sformatf("sat%0d", i));
        end
        idle("sat_end");
        check("sat_final", 32'(stall_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that drives the PC register's `hazardpc_i` hold input and the stall/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards and taken branches, and freezes the pipeline while the data memory is not ready. A bounded wait counter raises a sticky timeout error. A saturating counter records total PC-hold cycles for performance monitoring.

## Interface
- `TIMEOUT`, 16: consecutive memory-wait cycles that trigger the error state; legal range 2..65535.
- `CNT_W`, 32: width of the stall performance counter.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `id_rs1_i` in 5: rs1 index of the instruction in ID.
- `id_rs2_i` in 5: rs2 index of the instruction in ID.
- `id_use_rs1_i` in 1: the ID instruction reads rs1.
- `id_use_rs2_i` in 1: the ID instruction reads rs2.
- `ex_rd_i` in 5: rd index of the instruction in EX.
- `ex_memread_i` in 1: the EX instruction is a load.
- `branch_taken_i` in 1: the EX stage resolved a taken branch or jump this cycle.
- `mem_req_i` in 1: the MEM stage holds a load or store.
- `mem_ready_i` in 1: the data memory completes the access this cycle.
- `hazardpc_o` out 1: hold the PC; connects to the PC register's `hazardpc_i`.
- `hold_ifid_o` out 1: hold the IF/ID register.
- `flush_ifid_o` out 1: replace the IF/ID contents with a NOP.
- `hold_idex_o` out 1: hold the ID/EX register.
- `flush_idex_o` out 1: insert a bubble into ID/EX.
- `hold_exmem_o` out 1: hold the EX/MEM and MEM/WB registers.
- `mem_timeout_o` out 1: sticky error flag.
- `stall_cnt_o` out `CNT_W`: count of cycles in which `hazardpc_o` was 1.

## Operation
- Combinational terms:
  - `mem_stall = mem_req_i & ~mem_ready_i`.
  - `lu = ex_memread_i & (ex_rd_i != 0) & ((id_use_rs1_i & id_rs1_i == ex_rd_i) | (id_use_rs2_i & id_rs2_i == ex_rd_i))`.
- States: RUN, MEM_WAIT, ERROR. The state machine and `wait_cnt` (width `$clog2(TIMEOUT+1)`) are registered.
- Transitions:
  - RUN -> MEM_WAIT on an edge with `mem_stall`; `wait_cnt` becomes 1.
  - MEM_WAIT on an edge with `mem_stall`: `wait_cnt` increments. If the new value equals `TIMEOUT`, go to ERROR.
  - MEM_WAIT on an edge with `~mem_stall`: go to RUN and clear `wait_cnt`.
  - ERROR is held until reset.
- Outputs, evaluated in priority order; every output not listed in a row is 0:
  1. State ERROR: `hazardpc_o`, `hold_ifid_o`, `hold_idex_o`, `hold_exmem_o` and `mem_timeout_o` are 1.
  2. `mem_stall` (in RUN or MEM_WAIT): all four hold outputs are 1. No flush is issued, so a taken branch stays pending in EX until the freeze ends.
  3. `branch_taken_i`: `flush_ifid_o` and `flush_idex_o` are 1, and `hazardpc_o` is 0 so the PC loads the target. The load-use condition is ignored because that instruction is on the wrong path.
  4. `lu`: `hazardpc_o`, `hold_ifid_o` and `flush_idex_o` are 1, inserting one bubble.
  5. Otherwise all outputs are 0.
- Register x0 never causes a load-use hazard.
- `stall_cnt_o` increments on every edge where `hazardpc_o` is 1 and saturates at 2^`CNT_W`-1.

## Timing
- Reset: state RUN, `wait_cnt` 0, `stall_cnt_o` 0, `mem_timeout_o` 0.
  - During reset all control outputs are 0, except that the priority 2–5 combinational terms are still evaluated from the inputs.
- Control outputs have zero latency: they respond to the inputs in the same cycle. Only the timeout check depends on history.
- Load-use costs exactly 1 cycle. On the next edge the load moves to MEM, and `lu` deasserts unless a new hazard matches.
- Timeout:
  - `TIMEOUT` consecutive `mem_stall` cycles put the block in ERROR at the edge ending the `TIMEOUT`-th cycle.
  - `mem_timeout_o` is 1 from the following cycle onward.
  - `mem_ready_i` arriving in the `TIMEOUT`-th cycle clears `mem_stall`, so no error is raised.
- A break of a single cycle with `~mem_stall` resets the count.
- Asserting reset while in MEM_WAIT or ERROR returns the block to RUN immediately and asynchronously.

## Test plan
- Load-use hazard:
  - Stimulus: `ex_memread_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_use_rs2_i`=1.
  - Required response: `hazardpc_o`, `hold_ifid_o` and `flush_idex_o` are 1 for one cycle; `stall_cnt_o` goes 0 -> 1.
  - Repeat with `ex_rd_i`=0 and with `id_use_rs2_i`=0: no stall.
- Branch with load-use present:
  - Stimulus: `branch_taken_i`=1 together with the load-use condition.
  - Required response: `flush_ifid_o`=1, `flush_idex_o`=1, `hazardpc_o`=0.
- Memory wait:
  - Stimulus: `mem_req_i`=1, `mem_ready_i`=0 for 3 cycles with `branch_taken_i`=1, then `mem_ready_i`=1.
  - Required response:
    - During the 3 cycles: all holds are 1 and no flushes.
    - When `mem_ready_i`=1: the flushes fire in that cycle.
    - `stall_cnt_o`=3 at the end.
- Timeout, `TIMEOUT`=4:
  - 4 stall cycles -> ERROR; `mem_timeout_o`=1 from cycle 5 and stays 1 after `mem_ready_i` rises.
  - 3 stall cycles followed by ready -> no error.
- Reset in ERROR:
  - Stimulus: drop `rst_n` mid-cycle while in ERROR.
  - Required response: `mem_timeout_o` and `stall_cnt_o` are 0 immediately.
- Counter saturation:
  - Stimulus: `CNT_W`=4, 20 load-use cycles.
  - Required response: `stall_cnt_o`=15.
